// File: rtl/pc_gen.sv
// pc_gen -- program counter generator for an in-order fetch stage.
//
// Selects the next PC from (highest priority first): reset, trap/flush
// redirect, hold (!ena or stall), jalr, jal, taken conditional branch,
// sequential pc+4. Control-transfer targets whose low two bits are not 00
// are rejected: the PC holds and misalign_o pulses on the following cycle.
//
// Optional feature: define PC_GEN_RAS_EN to build a RAS_DEPTH-entry
// return-address stack that predicts jalr returns and reports matches on
// ras_hit_o. Without the macro ras_hit_o is tied low and the link inputs
// are unused.
//
// Parameters
//   PC_WIDTH   width of the PC, immediate and rs1 paths
//   RESET_PC   PC value loaded on reset
//   RAS_DEPTH  return-address-stack entries (power of 2, >= 2)
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   ena, stall           fetch enable / pipeline stall (either holds the PC)
//   redirect_valid/_pc   trap/flush redirect, applied even while held
//   branch, jump, jalr   conditional branch, jal and jalr flags
//   br_funct3            branch condition select
//   zero, lt, ltu        ALU compare flags
//   imm, rs1_data        sign-extended offset, jalr base
//   rd_is_link           rd is x1/x5
//   rs1_is_link          rs1 is x1/x5
//   pc_o                 registered current PC
//   next_pc_o            combinational PC loaded at the next edge
//   taken_o              combinational: control transfer accepted this cycle
//   misalign_o           registered pulse on a rejected misaligned target
//   ras_hit_o            registered pulse when the RAS prediction matched
module pc_gen #(
    parameter int unsigned         PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned         RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                branch,
    input  logic                jump,
    input  logic                jalr,
    input  logic [2:0]          br_funct3,
    input  logic                zero,
    input  logic                lt,
    input  logic                ltu,
    input  logic [PC_WIDTH-1:0] imm,
    input  logic [PC_WIDTH-1:0] rs1_data,
    input  logic                rd_is_link,
    input  logic                rs1_is_link,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic [PC_WIDTH-1:0] next_pc_o,
    output logic                taken_o,
    output logic                misalign_o,
    output logic                ras_hit_o
);

    logic                br_cond;
    logic                hold;
    logic                active;
    logic                ctrl;
    logic                target_bad;
    logic                mis_next;
    logic [PC_WIDTH-1:0] seq_pc;
    logic [PC_WIDTH-1:0] rel_pc;
    logic [PC_WIDTH-1:0] jalr_sum;
    logic [PC_WIDTH-1:0] jalr_pc;
    logic [PC_WIDTH-1:0] target;

    always_comb begin
        br_cond = 1'b0;
        case (br_funct3)
            3'b000:  br_cond = zero;
            3'b001:  br_cond = ~zero;
            3'b100:  br_cond = lt;
            3'b101:  br_cond = ~lt;
            3'b110:  br_cond = ltu;
            3'b111:  br_cond = ~ltu;
            default: br_cond = 1'b0;
        endcase
    end

    assign hold     = ~ena | stall;
    assign active   = ~rst & ~redirect_valid & ~hold;
    assign seq_pc   = pc_o + PC_WIDTH'(4);
    assign rel_pc   = pc_o + imm;
    assign jalr_sum = rs1_data + imm;
    assign jalr_pc  = {jalr_sum[PC_WIDTH-1:1], 1'b0};

    // jalr outranks jal, which shares the pc-relative target with branches
    assign ctrl       = jalr | jump | (branch & br_cond);
    assign target     = jalr ? jalr_pc : rel_pc;
    assign target_bad = ctrl & (target[1:0] != 2'b00);
    assign taken_o    = active & ctrl & ~target_bad;
    assign mis_next   = active & target_bad;

    always_comb begin
        if (rst)
            next_pc_o = RESET_PC;
        else if (redirect_valid)
            next_pc_o = redirect_pc;
        else if (hold || target_bad)
            next_pc_o = pc_o;
        else if (ctrl)
            next_pc_o = target;
        else
            next_pc_o = seq_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_o       <= RESET_PC;
            misalign_o <= 1'b0;
        end else begin
            pc_o       <= next_pc_o;
            misalign_o <= mis_next;
        end
    end

`ifdef PC_GEN_RAS_EN
    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_ptr;   // next free slot; top of stack is ras_ptr-1
    logic [CNT_W-1:0]    ras_cnt;
    logic [PTR_W-1:0]    top_idx;
    logic                ras_push;
    logic                ras_pop;

    assign top_idx  = ras_ptr - PTR_W'(1);
    assign ras_push = taken_o & (jump | jalr) & rd_is_link;
    // popping an empty stack is a no-op, so the empty case never pops
    assign ras_pop  = taken_o & jalr & rs1_is_link & (ras_cnt != '0);

    // Pop-then-push collapses to an in-place rewrite of the top entry.
    // A push on a full stack overwrites the oldest slot because the
    // pointer wraps while the count saturates.
    always_ff @(posedge clk) begin
        if (ras_pop && ras_push)
            ras_mem[top_idx] <= seq_pc;
        else if (ras_push)
            ras_mem[ras_ptr] <= seq_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_ptr   <= '0;
            ras_cnt   <= '0;
            ras_hit_o <= 1'b0;
        end else begin
            ras_hit_o <= ras_pop & (ras_mem[top_idx] == jalr_pc);
            if (ras_pop && !ras_push) begin
                ras_ptr <= top_idx;
                ras_cnt <= ras_cnt - CNT_W'(1);
            end else if (ras_push && !ras_pop) begin
                ras_ptr <= ras_ptr + PTR_W'(1);
                if (ras_cnt != CNT_W'(RAS_DEPTH))
                    ras_cnt <= ras_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_link;
    assign unused_link = rd_is_link ^ rs1_is_link;
    assign ras_hit_o   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen -- self-checking bench for pc_gen (RESET_PC = 8000_0000, depth 4).
// Directed vector table, hand-written multi-cycle sequences and a randomized
// phase, all compared against a behavioural next-PC / return-stack model.
`timescale 1ns/1ps
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam int unsigned DEPTH  = 4;
`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, ena, stall, redirect_valid;
    logic [31:0] redirect_pc;
    logic        branch, jump, jalr;
    logic [2:0]  br_funct3;
    logic        zero, lt, ltu;
    logic [31:0] imm, rs1_data;
    logic        rd_is_link, rs1_is_link;
    logic [31:0] pc_o, next_pc_o;
    logic        taken_o, misalign_o, ras_hit_o;

    pc_gen #(.PC_WIDTH(32), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .ena(ena), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch(branch), .jump(jump), .jalr(jalr), .br_funct3(br_funct3),
        .zero(zero), .lt(lt), .ltu(ltu), .imm(imm), .rs1_data(rs1_data),
        .rd_is_link(rd_is_link), .rs1_is_link(rs1_is_link),
        .pc_o(pc_o), .next_pc_o(next_pc_o), .taken_o(taken_o),
        .misalign_o(misalign_o), .ras_hit_o(ras_hit_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] m_pc;
    bit          m_mis, m_hit;
    logic [31:0] m_ras[$];

    typedef struct {
        logic [31:0] start_pc;
        logic        ena, stall, redir;
        logic [31:0] rpc;
        logic        branch, jump, jalr;
        logic [2:0]  f3;
        logic        z, l, u;
        logic [31:0] imm, rs1;
        logic [31:0] exp_next;
        logic        exp_taken, exp_mis;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bit br_taken(input logic [2:0] f, input logic z, input logic l, input logic u);
        case (f)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return l;
            3'b101:  return !l;
            3'b110:  return u;
            3'b111:  return !u;
            default: return 1'b0;
        endcase
    endfunction

    task automatic set_idle();
        rst = 0; ena = 1; stall = 0; redirect_valid = 0; redirect_pc = '0;
        branch = 0; jump = 0; jalr = 0; br_funct3 = '0;
        zero = 0; lt = 0; ltu = 0; imm = '0; rs1_data = '0;
        rd_is_link = 0; rs1_is_link = 0;
    endtask

    // One clock cycle with current inputs, checked against the model.
    task automatic cycle(input string tag);
        logic [31:0] e_next, tgt, top;
        bit          e_taken, e_mis, e_hit, has;
        e_taken = 0; e_mis = 0; e_hit = 0; has = 0; tgt = '0;
        if (rst)
            e_next = RST_PC;
        else if (redirect_valid)
            e_next = redirect_pc;
        else if (!ena || stall)
            e_next = m_pc;
        else begin
            if (jalr) begin
                has = 1; tgt = rs1_data + imm; tgt = tgt - (tgt % 2);
            end else if (jump || (branch && br_taken(br_funct3, zero, lt, ltu))) begin
                has = 1; tgt = m_pc + imm;
            end
            if (!has)
                e_next = m_pc + 4;
            else if (tgt % 4 != 0) begin
                e_next = m_pc; e_mis = 1;
            end else begin
                e_next = tgt; e_taken = 1;
            end
        end
        #1;
        chk({tag, "/next_pc"}, next_pc_o, e_next);
        if (!rst) chk({tag, "/taken"}, 32'(taken_o), 32'(e_taken));
        if (rst)
            m_ras.delete();
        else if (RAS_ON && e_taken) begin
            if (jalr && rs1_is_link && m_ras.size() > 0) begin
                top = m_ras.pop_back();
                e_hit = (top == tgt);
            end
            if ((jump || jalr) && rd_is_link) begin
                if (m_ras.size() == DEPTH) void'(m_ras.pop_front());
                m_ras.push_back(m_pc + 4);
            end
        end
        @(posedge clk); #1;
        m_pc = e_next; m_mis = e_mis; m_hit = e_hit;
        chk({tag, "/pc"}, pc_o, m_pc);
        chk({tag, "/misalign"}, 32'(misalign_o), 32'(m_mis));
        chk({tag, "/ras_hit"}, 32'(ras_hit_o), 32'(m_hit));
    endtask

    task automatic add_vec(input logic [31:0] sp, input logic en, input logic st, input logic rd,
                           input logic [31:0] rp, input logic b, input logic j, input logic jr,
                           input logic [2:0] f, input logic z, input logic l, input logic u,
                           input logic [31:0] im, input logic [31:0] r1,
                           input logic [31:0] en_pc, input logic et, input logic em);
        vec_t v;
        v.start_pc = sp; v.ena = en; v.stall = st; v.redir = rd; v.rpc = rp;
        v.branch = b; v.jump = j; v.jalr = jr; v.f3 = f; v.z = z; v.l = l; v.u = u;
        v.imm = im; v.rs1 = r1; v.exp_next = en_pc; v.exp_taken = et; v.exp_mis = em;
        vecs.push_back(v);
    endtask

    task automatic rand_cycle();
        set_idle();
        rst            = ($urandom_range(0, 63) == 0);
        redirect_valid = ($urandom_range(0, 15) == 0);
        redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
        ena            = ($urandom_range(0, 15) != 0);
        stall          = ($urandom_range(0, 7) == 0);
        case ($urandom_range(0, 7))
            0, 1, 2: branch = 1;
            3:       jump = 1;
            4:       jalr = 1;
            default: ;
        endcase
        br_funct3 = 3'($urandom);
        zero = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
        imm = 32'($urandom_range(0, 63)) * 4 - 128;
        if ($urandom_range(0, 7) == 0) imm = imm + $urandom_range(1, 3);
        rs1_data = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) rs1_data = rs1_data | $urandom_range(1, 3);
        rd_is_link = 1'($urandom); rs1_is_link = 1'($urandom);
        if (m_ras.size() > 0 && $urandom_range(0, 1) == 1) begin
            rs1_data = m_ras[$]; imm = '0;
        end
        cycle("rand");
    endtask

    logic [31:0] pushes[5]  = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
    logic [31:0] returns[5] = '{32'h54, 32'h44, 32'h34, 32'h24, 32'h14};

    initial begin
        set_idle();
        rst = 1;
        #1;
        // reset held two cycles, then sequential stepping
        cycle("rst0");
        chk("rst0_pc", pc_o, RST_PC);
        cycle("rst1");
        chk("rst1_pc", pc_o, RST_PC);
        rst = 0;
        cycle("run0");
        chk("run0_pc", pc_o, 32'h8000_0004);
        cycle("run1");
        chk("run1_pc", pc_o, 32'h8000_0008);

        //       start         ena st rd rpc     b  j  jr f3      z  l  u  imm           rs1           next          tk mis
        add_vec(32'h100,       1, 0, 0, 32'h0,  1, 0, 0, 3'b101, 0, 0, 0, 32'hFFFF_FFF0, 32'h0,        32'hF0,        1, 0);
        add_vec(32'h100,       1, 0, 0, 32'h0,  1, 0, 0, 3'b101, 0, 1, 0, 32'hFFFF_FFF0, 32'h0,        32'h104,       0, 0);
        add_vec(32'hFFFF_FFFC, 1, 0, 0, 32'h0,  0, 0, 0, 3'b000, 0, 0, 0, 32'h0,         32'h0,        32'h0,         0, 0);
        add_vec(32'h400,       1, 0, 0, 32'h0,  0, 0, 1, 3'b000, 0, 0, 0, 32'h0,         32'h303,      32'h400,       0, 1);
        add_vec(32'h300,       1, 1, 1, 32'h200,0, 1, 0, 3'b000, 0, 0, 0, 32'h40,        32'h0,        32'h200,       0, 0);
        add_vec(32'h300,       1, 1, 0, 32'h0,  0, 1, 0, 3'b000, 0, 0, 0, 32'h40,        32'h0,        32'h300,       0, 0);
        add_vec(32'h300,       0, 0, 0, 32'h0,  0, 1, 0, 3'b000, 0, 0, 0, 32'h40,        32'h0,        32'h300,       0, 0);
        add_vec(32'h1000,      1, 0, 0, 32'h0,  1, 0, 0, 3'b000, 1, 0, 0, 32'h8,         32'h0,        32'h1008,      1, 0);
        add_vec(32'h1000,      1, 0, 0, 32'h0,  1, 0, 0, 3'b001, 1, 0, 0, 32'h8,         32'h0,        32'h1004,      0, 0);
        add_vec(32'h1000,      1, 0, 0, 32'h0,  1, 0, 0, 3'b010, 1, 1, 1, 32'h8,         32'h0,        32'h1004,      0, 0);
        add_vec(32'h1000,      1, 0, 0, 32'h0,  1, 0, 0, 3'b110, 0, 0, 1, 32'hFFFF_FFFC, 32'h0,        32'hFFC,       1, 0);
        add_vec(32'h1000,      1, 0, 0, 32'h0,  1, 0, 0, 3'b111, 0, 0, 0, 32'h10,        32'h0,        32'h1010,      1, 0);
        add_vec(32'h1000,      1, 0, 0, 32'h0,  0, 1, 0, 3'b000, 0, 0, 0, 32'h20,        32'h0,        32'h1020,      1, 0);
        add_vec(32'h1000,      1, 0, 0, 32'h0,  0, 0, 1, 3'b000, 0, 0, 0, 32'h3,         32'h2001,     32'h2004,      1, 0);
        add_vec(32'h1000,      1, 0, 0, 32'h0,  0, 1, 0, 3'b000, 0, 0, 0, 32'h2,         32'h0,        32'h1000,      0, 1);
        add_vec(32'h1000,      1, 1, 0, 32'h0,  0, 0, 1, 3'b000, 0, 0, 0, 32'h0,         32'h303,      32'h1000,      0, 0);
        add_vec(32'h1000,      1, 0, 0, 32'h0,  0, 1, 1, 3'b000, 0, 0, 0, 32'h10,        32'h500,      32'h510,       1, 0);
        add_vec(32'hFFFF_FFFC, 1, 0, 0, 32'h0,  0, 1, 0, 3'b000, 0, 0, 0, 32'h8,         32'h0,        32'h4,         1, 0);

        foreach (vecs[i]) begin
            set_idle();
            redirect_valid = 1; redirect_pc = vecs[i].start_pc;
            cycle($sformatf("vec%0d_setup", i));
            set_idle();
            ena = vecs[i].ena; stall = vecs[i].stall;
            redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
            branch = vecs[i].branch; jump = vecs[i].jump; jalr = vecs[i].jalr;
            br_funct3 = vecs[i].f3; zero = vecs[i].z; lt = vecs[i].l; ltu = vecs[i].u;
            imm = vecs[i].imm; rs1_data = vecs[i].rs1;
            #1;
            chk($sformatf("vec%0d_next", i), next_pc_o, vecs[i].exp_next);
            chk($sformatf("vec%0d_taken", i), 32'(taken_o), 32'(vecs[i].exp_taken));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_pc", i), pc_o, vecs[i].exp_next);
            chk($sformatf("vec%0d_mis", i), 32'(misalign_o), 32'(vecs[i].exp_mis));
            chk($sformatf("vec%0d_hit", i), 32'(ras_hit_o), 32'd0);
            m_pc = vecs[i].exp_next; m_mis = vecs[i].exp_mis; m_hit = 0;
        end

        // misaligned jalr: PC holds, misalign pulses for exactly one cycle
        set_idle(); redirect_valid = 1; redirect_pc = 32'h400;
        cycle("mis_setup");
        set_idle(); jalr = 1; rs1_data = 32'h303;
        cycle("mis_jalr");
        chk("mis_pulse", 32'(misalign_o), 32'd1);
        chk("mis_hold_pc", pc_o, 32'h400);
        set_idle();
        cycle("mis_after");
        chk("mis_cleared", 32'(misalign_o), 32'd0);
        chk("mis_after_pc", pc_o, 32'h404);

        // reset wins over a stalled redirect
        set_idle(); stall = 1; jump = 1; imm = 32'h40;
        redirect_valid = 1; redirect_pc = 32'h200; rst = 1;
        cycle("rst_mid");
        chk("rst_mid_pc", pc_o, RST_PC);

        // five linked calls overflow the 4-deep stack; returns then pop newest first
        foreach (pushes[i]) begin
            set_idle(); redirect_valid = 1; redirect_pc = pushes[i];
            cycle("call_setup");
            set_idle(); jump = 1; imm = 32'h1000; rd_is_link = 1;
            cycle("call");
        end
        // a stalled, redirected call must leave the stack alone
        set_idle(); stall = 1; jump = 1; imm = 32'h1000; rd_is_link = 1;
        redirect_valid = 1; redirect_pc = 32'h200;
        cycle("redir_call");
        chk("redir_call_pc", pc_o, 32'h200);
        foreach (returns[i]) begin
            set_idle(); jalr = 1; rs1_is_link = 1; rs1_data = returns[i];
            cycle($sformatf("ret%0d", i));
            chk($sformatf("ret%0d_hit", i), 32'(ras_hit_o), (i < 4) ? 32'(RAS_ON) : 32'd0);
            chk($sformatf("ret%0d_pc", i), pc_o, returns[i]);
        end

        for (int n = 0; n < 3000; n++) rand_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
